uisccb_slave: RTL and testbench

UISCCB_SLAVE -- requirements
Module: uisccb_slave

---
 rtl/uisccb_pkg.sv | 26 ++
 rtl/uisccb_filter.sv | 95 +++++++++
 rtl/uisccb_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_uisccb_slave.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uisccb_pkg.sv
// Shared definitions for the SCCB/I2C register-access slave.
// Holds the controller state encoding, the default device address and the
// bus levels used for acknowledge and not-acknowledge bits.
package uisccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    ADDR_H,
    ACK_AH,
    ADDR_L,
    ACK_AL,
    WDATA,
    ACK_WD,
    RDATA,
    MACK,
    WAIT_STOP
  } state_t;

  localparam logic [7:0] DEFAULT_DEVID = 8'h78;

  localparam logic ACK_LEVEL  = 1'b0;
  localparam logic NACK_LEVEL = 1'b1;

endpackage

// File: rtl/uisccb_filter.sv
// Input conditioning for the SCL/SDA pair.
// Each line passes through a 2-FF synchronizer and a glitch filter that only
// accepts a new level after FILTER_LEN consecutive equal samples. From the
// filtered levels it produces single-cycle SCL edge pulses and START/STOP
// condition pulses.
//   clk_i, rst_n       : clock, synchronous active-low reset
//   scl_raw, sda_raw   : asynchronous bus lines
//   sda_lvl            : filtered SDA level
//   scl_rise, scl_fall : filtered SCL edge pulses
//   start_det          : SDA 1->0 while SCL high
//   stop_det           : SDA 0->1 while SCL high
module uisccb_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    scl_sync;
  logic [1:0]    sda_sync;
  logic [CW-1:0] scl_cnt;
  logic [CW-1:0] sda_cnt;
  logic          scl_lvl;
  logic          scl_q;
  logic          sda_q;

  // Two-stage synchronizers, preset to the idle-bus level so that leaving
  // reset on a quiet bus never looks like an edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_raw};
      sda_sync <= {sda_sync[0], sda_raw};
    end
  end

  // Glitch filters: the counter tracks how long the synchronized input has
  // disagreed with the accepted level; any agreeing sample restarts it.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      scl_lvl <= 1'b1;
      scl_cnt <= '0;
      sda_lvl <= 1'b1;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_lvl) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
        scl_lvl <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end

      if (sda_sync[1] == sda_lvl) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
        sda_lvl <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  // Previous filtered levels for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_lvl;
      sda_q <= sda_lvl;
    end
  end

  // START/STOP require SCL to have been high on both sides of the SDA edge.
  assign scl_rise  = scl_lvl & ~scl_q;
  assign scl_fall  = ~scl_lvl & scl_q;
  assign start_det = scl_lvl & scl_q & sda_q & ~sda_lvl;
  assign stop_det  = scl_lvl & scl_q & ~sda_q & sda_lvl;

endmodule

// File: rtl/uisccb_slave.sv
// SCCB/I2C slave giving a master byte access to a 16-bit register space.
// Write: DEVID, addr high, addr low, data...; read: DEVID|1, data...
// The register pointer persists across STOP so an address-only write
// followed by a separate read transaction works.
//   clk_i, rst_n : clock, synchronous active-low reset
//   iic_scl      : bus clock from the master (never stretched)
//   iic_sda      : open-drain data line, driven low or released
//   reg_addr     : current register pointer
//   reg_wr_en    : one-cycle write strobe with reg_wr_data
//   reg_rd_en    : one-cycle read request, reg_rd_data valid one cycle later
//   busy         : high between an accepted START and STOP
module uisccb_slave
  import uisccb_pkg::*;
#(
  parameter logic [7:0] DEVID      = DEFAULT_DEVID,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        iic_scl,
  inout  wire         iic_sda,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  output logic        busy
);

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       sda_oe;
  logic       rw;
  logic       rd_pending;

  logic       sda_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       rx_state;
  logic       last_bit;
  logic [7:0] rx_byte;

  uisccb_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .scl_raw   (iic_scl),
    .sda_raw   (iic_sda),
    .sda_lvl   (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Reset gates the driver directly so the line is freed without waiting
  // for a clock edge.
  assign iic_sda = (sda_oe && rst_n) ? ACK_LEVEL : 1'bz;

  assign rx_state = (state == DEV) || (state == ADDR_H) ||
                    (state == ADDR_L) || (state == WDATA);
  assign last_bit = (bit_cnt == 4'd7);
  assign rx_byte  = {shift[6:0], sda_f};

  // Protocol controller. STOP and START override everything. Received bits
  // shift in on SCL rising edges; all changes of our own SDA drive happen on
  // SCL falling edges. In the ACK states sda_oe doubles as the phase flag:
  // the first falling edge starts the ACK, the second one ends it.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      sda_oe      <= 1'b0;
      rw          <= 1'b0;
      rd_pending  <= 1'b0;
      busy        <= 1'b0;
      reg_addr    <= 16'h0000;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= 8'h00;
      reg_rd_en   <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      rd_pending <= reg_rd_en;

      if (rd_pending) begin
        shift <= reg_rd_data;
      end

      if (reg_wr_en) begin
        reg_addr <= reg_addr + 16'd1;
      end

      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_det) begin
        state   <= DEV;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= 4'd0;
      end else begin
        if (rx_state && scl_rise) begin
          shift   <= rx_byte;
          bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        end

        case (state)
          DEV: begin
            if (scl_rise && last_bit) begin
              if (rx_byte == DEVID) begin
                rw    <= 1'b0;
                state <= ACK_DEV;
              end else if (rx_byte == (DEVID | 8'h01)) begin
                rw        <= 1'b1;
                reg_rd_en <= 1'b1;
                state     <= ACK_DEV;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_H: begin
            if (scl_rise && last_bit) begin
              reg_addr[15:8] <= rx_byte;
              state          <= ACK_AH;
            end
          end

          ADDR_L: begin
            if (scl_rise && last_bit) begin
              reg_addr[7:0] <= rx_byte;
              state         <= ACK_AL;
            end
          end

          WDATA: begin
            if (scl_rise && last_bit) begin
              reg_wr_data <= rx_byte;
              reg_wr_en   <= 1'b1;
              state       <= ACK_WD;
            end
          end

          ACK_DEV, ACK_AH, ACK_AL, ACK_WD: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                case (state)
                  ACK_DEV: begin
                    if (rw) begin
                      sda_oe <= ~shift[7];
                      shift  <= {shift[6:0], 1'b0};
                      state  <= RDATA;
                    end else begin
                      state <= ADDR_H;
                    end
                  end
                  ACK_AH:  state <= ADDR_L;
                  default: state <= WDATA;
                endcase
              end
            end
          end

          // bit_cnt counts rising edges of the byte being sent; each
          // falling edge before the eighth rise puts the next bit out, the
          // one after it frees the line for the master's answer.
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                reg_addr <= reg_addr + 16'd1;
              end
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= MACK;
              end else begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end

          MACK: begin
            if (scl_rise) begin
              if (sda_f == NACK_LEVEL) begin
                state <= WAIT_STOP;
              end else begin
                reg_rd_en <= 1'b1;
                bit_cnt   <= 4'd0;
                state     <= RDATA;
              end
            end
          end

          IDLE, WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uisccb_slave.sv
// Self-checking bench for uisccb_slave: a bit-banged master on SCL/SDA,
// a register-file model answering read requests, and queues of expected
// and observed register writes.
`timescale 1ns/1ps
module tb_uisccb_slave;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_scl;
  logic        m_sda_low;
  wire         iic_sda;
  logic [15:0] reg_addr;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_data;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int dut_low_cnt = 0;

  logic [23:0] exp_wr_q[$];
  logic [23:0] obs_wr_q[$];
  logic [15:0] obs_rd_q[$];
  logic [7:0]  rd_model_q[$];

  always #5 clk = ~clk;

  pullup (iic_sda);
  assign iic_sda = m_sda_low ? 1'b0 : 1'bz;

  uisccb_slave #(
    .DEVID      (8'h78),
    .FILTER_LEN (3)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .iic_scl     (m_scl),
    .iic_sda     (iic_sda),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  // Register-file model: a read request is answered one cycle later with
  // the next queued byte.
  always @(posedge clk) begin
    if (reg_rd_en === 1'b1) begin
      if (rd_model_q.size() > 0) reg_rd_data <= rd_model_q.pop_front();
      else reg_rd_data <= 8'hEE;
    end
  end

  // Monitor sampling a little after each rising edge: records strobes and
  // counts cycles where the DUT alone holds SDA low.
  always begin
    @(posedge clk);
    #2;
    if (reg_wr_en === 1'b1) obs_wr_q.push_back({reg_addr, reg_wr_data});
    if (reg_rd_en === 1'b1) obs_rd_q.push_back(reg_addr);
    if (!m_sda_low && iic_sda === 1'b0) dut_low_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  // Master writes one byte MSB first, optionally injecting one-cycle
  // glitches on SCL (low phase) and SDA (high phase); returns the ACK seen.
  task automatic applyStimulus(input logic [7:0] data, input bit glitch,
                               output logic acked);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~data[i];
      if (glitch) begin
        wait_clk(2);
        m_scl = 1'b1;
        wait_clk(1);
        m_scl = 1'b0;
        wait_clk(Q - 3);
      end else begin
        wait_clk(Q);
      end
      m_scl = 1'b1;
      if (glitch) begin
        wait_clk(4);
        m_sda_low = data[i];
        wait_clk(1);
        m_sda_low = ~data[i];
        wait_clk(2 * Q - 5);
      end else begin
        wait_clk(2 * Q);
      end
      m_scl = 1'b0;
      wait_clk(Q);
    end
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    acked = (iic_sda === 1'b0);
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic readByte(input bit master_ack, output logic [7:0] data);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      data[i] = iic_sda;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
    end
    m_sda_low = master_ack;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(2 * Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_wr_count"}, obs_wr_q.size(), exp_wr_q.size());
    while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
      checkOutput({tag, "_wr_addr_data"}, obs_wr_q.pop_front(), exp_wr_q.pop_front());
    end
    obs_wr_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    logic       acked;
    logic [7:0] rx;
    int         ack_cnt;
    int         low_snap;
    logic [7:0] burst[6];
    logic [15:0] exp_rd_addr[2];

    rst_n       = 1'b0;
    m_scl       = 1'b1;
    m_sda_low   = 1'b0;
    reg_rd_data = 8'h00;
    wait_clk(4);

    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_reg_addr", reg_addr, 16'h0000);
    checkOutput("rst_wr_en", reg_wr_en, 1'b0);
    checkOutput("rst_rd_en", reg_rd_en, 1'b0);
    checkOutput("rst_wr_data", reg_wr_data, 8'h00);
    checkOutput("rst_sda", iic_sda, 1'b1);
    rst_n = 1'b1;
    wait_clk(4);
    obs_wr_q.delete();
    obs_rd_q.delete();

    $display("[TB] single register write");
    exp_wr_q.push_back({16'h3008, 8'h82});
    bus_start();
    checkOutput("w1_busy", busy, 1'b1);
    applyStimulus(8'h78, 1'b0, acked);
    checkOutput("w1_ack_dev", acked, 1'b1);
    applyStimulus(8'h30, 1'b0, acked);
    checkOutput("w1_ack_ah", acked, 1'b1);
    applyStimulus(8'h08, 1'b0, acked);
    checkOutput("w1_ack_al", acked, 1'b1);
    applyStimulus(8'h82, 1'b0, acked);
    checkOutput("w1_ack_wd", acked, 1'b1);
    bus_stop();
    checkOutput("w1_busy_after_stop", busy, 1'b0);
    checkWrites("w1");
    checkOutput("w1_final_addr", reg_addr, 16'h3009);

    $display("[TB] wrong device address");
    low_snap = dut_low_cnt;
    bus_start();
    applyStimulus(8'h7A, 1'b0, acked);
    checkOutput("nd_ack", acked, 1'b0);
    checkOutput("nd_busy", busy, 1'b1);
    applyStimulus(8'h55, 1'b0, acked);
    bus_stop();
    checkOutput("nd_sda_never_low", dut_low_cnt - low_snap, 0);
    checkOutput("nd_busy_after_stop", busy, 1'b0);
    checkOutput("nd_rd_count", obs_rd_q.size(), 0);
    checkWrites("nd");
    checkOutput("nd_addr_kept", reg_addr, 16'h3009);

    $display("[TB] burst write across address wrap");
    burst = '{8'h78, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33};
    exp_wr_q.push_back({16'hFFFF, 8'h11});
    exp_wr_q.push_back({16'h0000, 8'h22});
    exp_wr_q.push_back({16'h0001, 8'h33});
    ack_cnt = 0;
    bus_start();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(burst[i], 1'b0, acked);
      if (acked === 1'b1) ack_cnt++;
    end
    bus_stop();
    checkOutput("bw_ack_count", ack_cnt, 6);
    checkWrites("bw");
    checkOutput("bw_final_addr", reg_addr, 16'h0002);

    $display("[TB] SCCB read: address write, stop, read two bytes");
    bus_start();
    applyStimulus(8'h78, 1'b0, acked);
    applyStimulus(8'h30, 1'b0, acked);
    applyStimulus(8'h0A, 1'b0, acked);
    checkOutput("rd_ack_al", acked, 1'b1);
    bus_stop();
    checkWrites("rd_setup");
    checkOutput("rd_addr_after_stop", reg_addr, 16'h300A);
    rd_model_q.push_back(8'h56);
    rd_model_q.push_back(8'h40);
    obs_rd_q.delete();
    bus_start();
    applyStimulus(8'h79, 1'b0, acked);
    checkOutput("rd_ack_dev", acked, 1'b1);
    readByte(1'b1, rx);
    checkOutput("rd_byte0", rx, 8'h56);
    readByte(1'b0, rx);
    checkOutput("rd_byte1", rx, 8'h40);
    checkOutput("rd_sda_released", iic_sda, 1'b1);
    bus_stop();
    checkOutput("rd_en_count", obs_rd_q.size(), 2);
    exp_rd_addr = '{16'h300A, 16'h300B};
    for (int i = 0; i < 2; i++) begin
      if (obs_rd_q.size() > 0) checkOutput("rd_en_addr", obs_rd_q.pop_front(), exp_rd_addr[i]);
    end
    checkOutput("rd_final_addr", reg_addr, 16'h300C);
    checkWrites("rd");

    $display("[TB] write with one-cycle glitches");
    exp_wr_q.push_back({16'h4000, 8'h5A});
    ack_cnt = 0;
    bus_start();
    applyStimulus(8'h78, 1'b1, acked);
    if (acked === 1'b1) ack_cnt++;
    applyStimulus(8'h40, 1'b1, acked);
    if (acked === 1'b1) ack_cnt++;
    applyStimulus(8'h00, 1'b1, acked);
    if (acked === 1'b1) ack_cnt++;
    applyStimulus(8'h5A, 1'b1, acked);
    if (acked === 1'b1) ack_cnt++;
    bus_stop();
    checkOutput("gl_ack_count", ack_cnt, 4);
    checkWrites("gl");
    checkOutput("gl_final_addr", reg_addr, 16'h4001);

    $display("[TB] reset while driving read data");
    rd_model_q.delete();
    rd_model_q.push_back(8'h00);
    bus_start();
    applyStimulus(8'h79, 1'b0, acked);
    checkOutput("rs_ack_dev", acked, 1'b1);
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    checkOutput("rs_sda_driven", iic_sda, 1'b0);
    rst_n = 1'b0;
    wait_clk(1);
    checkOutput("rs_sda_released", iic_sda, 1'b1);
    checkOutput("rs_busy", busy, 1'b0);
    checkOutput("rs_addr", reg_addr, 16'h0000);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
    obs_wr_q.delete();
    exp_wr_q.push_back({16'h1234, 8'hAB});
    ack_cnt = 0;
    bus_start();
    applyStimulus(8'h78, 1'b0, acked);
    if (acked === 1'b1) ack_cnt++;
    applyStimulus(8'h12, 1'b0, acked);
    if (acked === 1'b1) ack_cnt++;
    applyStimulus(8'h34, 1'b0, acked);
    if (acked === 1'b1) ack_cnt++;
    applyStimulus(8'hAB, 1'b0, acked);
    if (acked === 1'b1) ack_cnt++;
    bus_stop();
    checkOutput("rs_ack_count", ack_cnt, 4);
    checkWrites("rs");
    checkOutput("rs_final_addr", reg_addr, 16'h1235);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
